img_ram_arbiter: RTL and testbench
==================================

Name: img_ram_arbiter

Overview:
Shares the single read/write port of the image block RAM between two requesters. The first is the real-time video window fetcher, which issues reads for the Sobel 3x3 window. The second is a host loader (UART/debug path) that writes new image data or reads pixels back. Video always wins. The host gets the port only outside active video, and in bounded bursts. The block also provides a read-return pipeline per requester and a sticky host-starvation flag.

Parameters:
ADDR_W, 14, RAM address width (128*96 = 12288 words)
DATA_W, 8, pixel width
HOST_BURST, 16, max consecutive host transfers before a forced 1-cycle gap
MAX_WAIT, 1023, host wait cycles (h_req high, no transfer) that set h_starve

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
vid_active  in  1  high during the visible/fetch window; host locked out while high
v_req  in  1  video read request; always accepted in the same cycle
v_addr  in  ADDR_W  video read address
v_rdata  out  DATA_W  video read data
v_valid  out  1  v_rdata valid strobe
h_req  in  1  host request (valid)
h_we  in  1  host 1=write, 0=read
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_gnt  out  1  host ready; transfer occurs when h_req & h_gnt
h_rdata  out  DATA_W  host read data
h_valid  out  1  h_rdata valid strobe
h_starve  out  1  sticky starvation flag
starve_clr  in  1  clears h_starve
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data; 1-cycle latency after ram_en

Behaviour:
- Reset values: ram_en/ram_we = 0; ram_addr/ram_wdata = 0; v_valid/h_valid = 0; v_rdata/h_rdata = 0; h_starve = 0; burst counter, wait counter and return tags cleared. State = IDLE.
- Reset mid-operation: in-flight reads are discarded. No v_valid/h_valid is asserted for any request issued before reset.
- h_gnt is combinational: h_req & ~v_req & ~vid_active & ~gap & ~rst.
- gap = 1 for exactly one cycle after HOST_BURST consecutive host transfers.
- v_req has no backpressure. Every v_req cycle is accepted.
- States (owner of the command registered this edge): IDLE, VID, HOST.
  - v_req → VID.
  - else h_req & h_gnt → HOST.
  - else → IDLE.
  - Evaluated every cycle; any state can go to any state; no bubble on owner switch.
- Command timing: request accepted in cycle t → ram_en/ram_we/ram_addr/ram_wdata registered, driven during t+1.
  - IDLE drives ram_en = 0, ram_we = 0; addr/wdata hold their previous value.
  - VID: ram_we = 0.
  - HOST: ram_we = h_we.
- Read return: 1-bit owner tag pipelined alongside the command. ram_rdata is captured at the end of t+2 into v_rdata or h_rdata.
  - The matching valid is high during t+3 for one cycle. Read latency = 3 cycles.
  - Host writes produce no h_valid.
  - Back-to-back reads give back-to-back valids in order.
  - rdata regs hold their value when not updated.
- Burst counter:
  - +1 on each host transfer.
  - Cleared on any cycle without a host transfer, including video preemption.
  - On reaching HOST_BURST: gap asserted next cycle, counter cleared.
- Wait counter:
  - +1 (saturating at MAX_WAIT) each cycle with h_req & ~h_gnt.
  - Cleared on a host transfer or when h_req = 0.
  - Reaching MAX_WAIT sets h_starve.
- h_starve: cleared by starve_clr. If set and clear occur in the same cycle, set wins.
- vid_active rising while the host is mid-burst: h_gnt drops in that same cycle. An already registered host command still completes.

Test Plan:
- Reset → all outputs 0. v_req with v_addr = 5 at t, ram_rdata = 8'hA5 at t+2 → ram_en = 1, ram_addr = 5, ram_we = 0 at t+1; v_valid = 1, v_rdata = A5 at t+3.
- v_req and h_req (write, addr 100) together, vid_active = 0 → h_gnt = 0, video served. v_req low next cycle → h_gnt = 1, ram_we = 1, ram_addr = 100 the following cycle.
- vid_active = 1, h_req held 10 cycles, no v_req → h_gnt = 0 throughout, ram_en = 0. Drop vid_active → transfer on the next cycle.
- h_req held continuously, vid_active = 0, no video → 16 transfers, 1 gap cycle with h_gnt = 0, then 16 more.
- Interleaved host read addr 7 and video read addr 9 on consecutive cycles → h_valid then v_valid on consecutive cycles, each with the correct data.
- h_req blocked by vid_active for 1023 cycles → h_starve = 1. starve_clr → 0. Reset during an in-flight read → no valid strobe afterwards.

Source files
------------

// File: rtl/img_ram_arbiter.sv
// Shares the image block RAM port between the video window fetcher (always wins)
// and the host loader, with per-requester read return and host starvation tracking.
module img_ram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int HOST_BURST = 16,
  parameter int MAX_WAIT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_active,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic [DATA_W-1:0] v_rdata,
  output logic              v_valid,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_valid,
  output logic              h_starve,
  input  logic              starve_clr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int BURST_W = $clog2(HOST_BURST + 1);
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(HOST_BURST - 1);
  localparam logic [WAIT_W-1:0]  WAIT_SET   = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_WAIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VID  = 2'd1;
  localparam logic [1:0] HOST = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic               gap;
  logic               h_xfer;
  logic               h_block;
  logic [BURST_W-1:0] burst_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               rd_p2;
  logic               vid_p2;

  assign h_gnt   = h_req & ~v_req & ~vid_active & ~gap & ~rst;
  assign h_xfer  = h_req & h_gnt;
  assign h_block = h_req & ~h_gnt;

  always_comb begin
    state_next = IDLE;
    if (v_req)
      state_next = VID;
    else if (h_xfer)
      state_next = HOST;
  end

  // Stage p1: command registered at the edge ending the accept cycle; state names its owner
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state  <= state_next;
      ram_en <= v_req | h_xfer;
      ram_we <= ~v_req & h_xfer & h_we;
      if (v_req) begin
        ram_addr <= v_addr;
      end else if (h_xfer) begin
        ram_addr  <= h_addr;
        ram_wdata <= h_wdata;
      end
    end
  end

  // Stage p2: tag travels while the RAM produces data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p2  <= 1'b0;
      vid_p2 <= 1'b0;
    end else begin
      rd_p2  <= (state == VID) | ((state == HOST) & ~ram_we);
      vid_p2 <= (state == VID);
    end
  end

  // Stage p3: capture RAM data into the owner's return register
  always_ff @(posedge clk) begin
    if (rst) begin
      v_valid <= 1'b0;
      h_valid <= 1'b0;
      v_rdata <= '0;
      h_rdata <= '0;
    end else begin
      v_valid <= rd_p2 & vid_p2;
      h_valid <= rd_p2 & ~vid_p2;
      if (rd_p2 & vid_p2)
        v_rdata <= ram_rdata;
      if (rd_p2 & ~vid_p2)
        h_rdata <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      gap       <= 1'b0;
    end else if (h_xfer) begin
      if (burst_cnt == BURST_LAST) begin
        burst_cnt <= '0;
        gap       <= 1'b1;
      end else begin
        burst_cnt <= burst_cnt + 1'b1;
        gap       <= 1'b0;
      end
    end else begin
      burst_cnt <= '0;
      gap       <= 1'b0;
    end
  end

  // Starvation set takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      h_starve <= 1'b0;
    end else begin
      if (h_block) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (h_block && (wait_cnt >= WAIT_SET))
        h_starve <= 1'b1;
      else if (starve_clr)
        h_starve <= 1'b0;
    end
  end

endmodule

// File: tb/tb_img_ram_arbiter.sv
// Directed bench for img_ram_arbiter: per-cycle vector table plus hand sequences
// for lockout, burst gap, starvation and reset during in-flight reads.
module tb_img_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        vid_active;
  logic        v_req;
  logic [13:0] v_addr;
  logic [7:0]  v_rdata;
  logic        v_valid;
  logic        h_req;
  logic        h_we;
  logic [13:0] h_addr;
  logic [7:0]  h_wdata;
  logic        h_gnt;
  logic [7:0]  h_rdata;
  logic        h_valid;
  logic        h_starve;
  logic        starve_clr;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  img_ram_arbiter dut (
    .clk(clk), .rst(rst), .vid_active(vid_active),
    .v_req(v_req), .v_addr(v_addr), .v_rdata(v_rdata), .v_valid(v_valid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_valid(h_valid),
    .h_starve(h_starve), .starve_clr(starve_clr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v_req;
    logic [13:0] v_addr;
    logic        h_req;
    logic        h_we;
    logic [13:0] h_addr;
    logic [7:0]  h_wdata;
    logic [7:0]  rdata;
    logic        gnt;
    logic        en;
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic        vv;
    logic [7:0]  vd;
    logic        hv;
    logic [7:0]  hd;
  } vec_t;

  vec_t tbl[13];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vid_active = 0; v_req = 0; v_addr = 0; h_req = 0; h_we = 0;
    h_addr = 0; h_wdata = 0; starve_clr = 0; ram_rdata = 0;
  endtask

  initial begin
    // Inputs: v_req v_addr h_req h_we h_addr h_wdata rdata | gnt en we addr wdata vv vd hv hd
    tbl[0]  = '{1, 5,   0, 0, 0,   0,    0,    0, 0, 0, 0,   0,    0, 0,    0, 0};
    tbl[1]  = '{0, 0,   0, 0, 0,   0,    0,    0, 1, 0, 5,   0,    0, 0,    0, 0};
    tbl[2]  = '{0, 0,   0, 0, 0,   0,    8'hA5, 0, 0, 0, 0,  0,    0, 0,    0, 0};
    tbl[3]  = '{0, 0,   0, 0, 0,   0,    0,    0, 0, 0, 0,   0,    1, 8'hA5, 0, 0};
    tbl[4]  = '{1, 3,   1, 1, 100, 8'h3C, 0,   0, 0, 0, 0,   0,    0, 0,    0, 0};
    tbl[5]  = '{0, 0,   1, 1, 100, 8'h3C, 0,   1, 1, 0, 3,   0,    0, 0,    0, 0};
    tbl[6]  = '{0, 0,   0, 0, 0,   0,    8'h11, 0, 1, 1, 100, 8'h3C, 0, 0,   0, 0};
    tbl[7]  = '{0, 0,   0, 0, 0,   0,    0,    0, 0, 0, 0,   0,    1, 8'h11, 0, 0};
    tbl[8]  = '{0, 0,   1, 0, 7,   0,    0,    1, 0, 0, 0,   0,    0, 0,    0, 0};
    tbl[9]  = '{1, 9,   0, 0, 0,   0,    0,    0, 1, 0, 7,   0,    0, 0,    0, 0};
    tbl[10] = '{0, 0,   0, 0, 0,   0,    8'h77, 0, 1, 0, 9,  0,    0, 0,    0, 0};
    tbl[11] = '{0, 0,   0, 0, 0,   0,    8'h99, 0, 0, 0, 0,  0,    0, 0,    1, 8'h77};
    tbl[12] = '{0, 0,   0, 0, 0,   0,    0,    0, 0, 0, 0,   0,    1, 8'h99, 0, 0};

    idle_inputs();
    rst = 1;
    h_req = 1;
    tick(); tick(); tick();
    #1;
    chk("rst_gnt", h_gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_v_valid", v_valid, 0);
    chk("rst_h_valid", h_valid, 0);
    chk("rst_v_rdata", v_rdata, 0);
    chk("rst_h_rdata", h_rdata, 0);
    chk("rst_h_starve", h_starve, 0);
    h_req = 0;
    rst = 0;
    tick();

    for (int i = 0; i < 13; i++) begin
      v_req = tbl[i].v_req; v_addr = tbl[i].v_addr;
      h_req = tbl[i].h_req; h_we = tbl[i].h_we;
      h_addr = tbl[i].h_addr; h_wdata = tbl[i].h_wdata;
      ram_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d_gnt", i), h_gnt, tbl[i].gnt);
      chk($sformatf("row%0d_ram_en", i), ram_en, tbl[i].en);
      chk($sformatf("row%0d_v_valid", i), v_valid, tbl[i].vv);
      chk($sformatf("row%0d_h_valid", i), h_valid, tbl[i].hv);
      if (tbl[i].en) begin
        chk($sformatf("row%0d_ram_we", i), ram_we, tbl[i].we);
        chk($sformatf("row%0d_ram_addr", i), ram_addr, tbl[i].addr);
      end
      if (tbl[i].we) chk($sformatf("row%0d_ram_wdata", i), ram_wdata, tbl[i].wdata);
      if (tbl[i].vv) chk($sformatf("row%0d_v_rdata", i), v_rdata, tbl[i].vd);
      if (tbl[i].hv) chk($sformatf("row%0d_h_rdata", i), h_rdata, tbl[i].hd);
      tick();
    end
    idle_inputs();
    tick();

    // Host locked out during active video, then mid-burst preemption
    vid_active = 1; h_req = 1; h_we = 1; h_addr = 200;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("lock%0d_gnt", i), h_gnt, 0);
      chk($sformatf("lock%0d_ram_en", i), ram_en, 0);
      tick();
    end
    vid_active = 0;
    #1;
    chk("unlock_gnt", h_gnt, 1);
    tick();
    chk("unlock_ram_en", ram_en, 1);
    chk("unlock_ram_addr", ram_addr, 200);
    h_addr = 201;
    tick();
    vid_active = 1;
    #1;
    chk("preempt_gnt", h_gnt, 0);
    chk("preempt_inflight_en", ram_en, 1);
    chk("preempt_inflight_addr", ram_addr, 201);
    tick();
    chk("preempt_after_en", ram_en, 0);
    idle_inputs();
    tick();

    // Continuous host requests: 16 transfers, one gap, 16 more
    h_req = 1; h_we = 1; h_addr = 50;
    for (int i = 0; i < 33; i++) begin
      #1;
      chk($sformatf("burst%0d_gnt", i), h_gnt, (i != 16));
      if (i > 0) chk($sformatf("burst%0d_ram_en", i), ram_en, (i != 17));
      tick();
    end
    h_req = 0;
    #1;
    chk("burst_end_ram_en", ram_en, 1);
    tick();

    // Starvation: host blocked for MAX_WAIT cycles
    vid_active = 1; h_req = 1;
    for (int i = 0; i < 1023; i++) begin
      if (i == 1022) begin
        #1;
        chk("starve_before", h_starve, 0);
      end
      tick();
    end
    chk("starve_set", h_starve, 1);
    h_req = 0; vid_active = 0;
    tick();
    chk("starve_sticky", h_starve, 1);
    starve_clr = 1;
    tick();
    starve_clr = 0;
    chk("starve_cleared", h_starve, 0);

    // Reset while a host read and a video read are in flight
    h_req = 1; h_we = 0; h_addr = 7;
    #1;
    chk("rstflight_gnt", h_gnt, 1);
    tick();
    h_req = 0; v_req = 1; v_addr = 9;
    tick();
    v_req = 0; rst = 1; ram_rdata = 8'h5A;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rstflight%0d_v_valid", i), v_valid, 0);
      chk($sformatf("rstflight%0d_h_valid", i), h_valid, 0);
      chk($sformatf("rstflight%0d_ram_en", i), ram_en, 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
